// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit: datapath
// width, the funct3 operation encoding (also used by decode and the EX stage)
// and the sequencer state encoding. The helper functions classify an
// operation so the decode rules live in exactly one place.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  // REM/REMU share funct3[1] among the divide group.
  function automatic logic is_rem(input op_e op);
    return op[2] & op[1];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV)  || (op == OP_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM (not MULHSU).
  function automatic logic b_is_signed(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix
// Purely combinational sign handling around the unsigned core datapath.
//   PREP side: a_raw/b_raw/op -> neg_a/neg_b (operand is a signed negative)
//              and mag_a/mag_b (absolute values fed to the core).
//   FIX side : acc (64-bit product, or {remainder, quotient}) plus the
//              recorded signs sign_a/sign_b -> fixed (final 32-bit result
//              selected for op_fix).
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   a_raw,
  input  logic [XLEN-1:0]   b_raw,
  input  op_e               op_prep,
  output logic              neg_a,
  output logic              neg_b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  input  op_e               op_fix,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   fixed
);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  // Magnitudes: only operands the op treats as signed get negated.
  always_comb begin
    neg_a = a_is_signed(op_prep) & a_raw[XLEN-1];
    neg_b = b_is_signed(op_prep) & b_raw[XLEN-1];
    mag_a = neg_a ? (~a_raw + 1'b1) : a_raw;
    mag_b = neg_b ? (~b_raw + 1'b1) : b_raw;
  end

  // Product and quotient take the XOR of the signs; the remainder follows
  // the dividend so that quotient*divisor + remainder == dividend.
  always_comb begin
    prod  = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo   = (sign_a ^ sign_b) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem   = sign_a ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    fixed = '0;
    case (op_fix)
      OP_MUL:                         fixed = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fixed = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                fixed = quo;
      OP_REM, OP_REMU:                fixed = rem;
      default:                        fixed = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit. One operand bit per cycle through a
// shared 64-bit accumulator: shift-add for multiply, restoring
// shift-subtract for divide. Divide-by-zero and signed overflow bypass the
// iteration.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, only honoured in IDLE
//   op              RV32M funct3
//   a_in, b_in      rs1 / rs2 operands, captured when start is accepted
//   flush           synchronous kill, returns to IDLE without a done pulse
//   busy            high whenever not IDLE
//   done            one-cycle pulse, result valid in that cycle
//   result          last completed result, held until the next completion
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state;
  state_e            state_next;
  op_e               op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic              sign_a_q;
  logic              sign_b_q;
  logic              special_q;
  logic [4:0]        cnt;
  logic [XLEN-1:0]   addend;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   res_fix;

  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   fixed;

  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic [XLEN-1:0]   special_val;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .a_raw   (a_q),
    .b_raw   (b_q),
    .op_prep (op_q),
    .neg_a   (neg_a),
    .neg_b   (neg_b),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .op_fix  (op_q),
    .sign_a  (sign_a_q),
    .sign_b  (sign_b_q),
    .acc     (acc),
    .fixed   (fixed)
  );

  // Cases whose architectural result is fixed and needs no iteration.
  always_comb begin
    div_zero    = is_div(op_q) && (b_q == '0);
    div_ovf     = ((op_q == OP_DIV) || (op_q == OP_REM)) &&
                  (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    special     = div_zero || div_ovf;
    special_val = '0;
    if (div_zero)
      special_val = is_rem(op_q) ? a_q : '1;
    else if (div_ovf)
      special_val = is_rem(op_q) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration step. Multiply: acc = {partial hi, multiplier}, add the
  // multiplicand when the LSB is set, then shift right through the carry.
  // Divide: acc = {remainder, dividend/quotient}, shift left one bit and
  // keep the trial subtraction if it does not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    rem_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = rem_shift - {1'b0, addend};
    if (!div_diff[XLEN])
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      div_next = {acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; flush overrides everything, including start in IDLE.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_next = ST_PREP;
        ST_PREP: state_next = special ? ST_FIX : ST_CALC;
        ST_CALC: if (cnt == 5'd0) state_next = ST_FIX;
        ST_FIX:  state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Datapath. result/done are registered out of DONE so the pulse and the
  // new value appear together in the cycle after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MUL;
      a_q       <= '0;
      b_q       <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      special_q <= 1'b0;
      cnt       <= 5'd0;
      addend    <= '0;
      acc       <= '0;
      res_fix   <= '0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            op_q <= op_e'(op);
            a_q  <= a_in;
            b_q  <= b_in;
          end
        end
        ST_PREP: begin
          sign_a_q  <= neg_a;
          sign_b_q  <= neg_b;
          special_q <= special;
          cnt       <= 5'd31;
          if (special) begin
            acc    <= {{XLEN{1'b0}}, special_val};
            addend <= '0;
          end else if (is_div(op_q)) begin
            acc    <= {{XLEN{1'b0}}, mag_a};
            addend <= mag_b;
          end else begin
            acc    <= {{XLEN{1'b0}}, mag_b};
            addend <= mag_a;
          end
        end
        ST_CALC: begin
          if (!flush) begin
            acc <= is_div(op_q) ? div_next : mul_next;
            if (cnt != 5'd0)
              cnt <= cnt - 5'd1;
          end
        end
        ST_FIX: begin
          res_fix <= special_q ? acc[XLEN-1:0] : fixed;
        end
        ST_DONE: begin
          if (!flush) begin
            result <= res_fix;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Directed vectors with hand-computed results and latencies for
// muldiv_unit, plus flush, start-while-busy and mid-operation reset cases.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int compared;
  int mismatched;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if something hangs beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue one op, scramble the operand inputs after acceptance, and wait
  // (bounded) for done. lat counts edges after the accepting edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, output logic [31:0] res,
                               output int lat, output logic busyOk);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; a_in = $urandom; b_in = $urandom;
    lat = 0;
    busyOk = busy;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) busyOk = 1'b0;
    end
    res = result;
  endtask

  task automatic runOp(input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expRes, input int expLat);
    logic [31:0] res;
    int          lat;
    logic        busyOk;
    applyStimulus(o, a, b, res, lat, busyOk);
    checkOutput({tag, "_result"}, res, expRes);
    checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_busy"}, {31'd0, busyOk}, 32'd1);
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    logic        sawDone;

    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a_in = '0; b_in = '0; flush = 1'b0;
    #12;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("mul_neg",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35);
    runOp("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35);
    runOp("mul_max",     3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 35);
    runOp("mulh_m1m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35);
    runOp("mulh_min2",   3'b001, 32'h80000000, 32'd2,        32'hFFFFFFFF, 35);
    runOp("mulhsu_m1",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35);
    runOp("div_neg7_2",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35);
    runOp("rem_neg7_2",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35);
    runOp("div_7_neg2",  3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 35);
    runOp("rem_7_neg2",  3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 35);
    runOp("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14,       35);
    runOp("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2,        35);
    runOp("divu_max_1",  3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 35);
    runOp("divu_by0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 3);
    runOp("rem_by0",     3'b110, 32'd7,        32'd0,        32'd7,        3);
    runOp("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3);
    runOp("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 3);

    // start while busy must be ignored: DIVU 100/7 keeps its result/latency.
    @(negedge clk);
    start = 1'b1; op = 3'b101; a_in = 32'd100; b_in = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start = 1'b1; op = 3'b000; a_in = 32'd9; b_in = 32'd9;
    @(posedge clk); #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    checkOutput("ignore_start_result", result, 32'd14);
    checkOutput("ignore_start_latency", lat, 35);

    // Flush in CALC: back to IDLE next edge, no done, result kept (14).
    @(negedge clk);
    start = 1'b1; op = 3'b100; a_in = 32'd1000; b_in = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    sawDone = 1'b0;
    repeat (40) begin @(posedge clk); #1; sawDone |= done; end
    checkOutput("flush_nodone", {31'd0, sawDone}, 32'd0);
    checkOutput("flush_result", result, 32'd14);

    // Asynchronous reset mid-CALC clears outputs immediately.
    @(negedge clk);
    start = 1'b1; op = 3'b000; a_in = 32'd5; b_in = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("mul_after_reset", 3'b000, 32'd3, 32'd4, 32'd12, 35);

    applyStimulus(3'b111, 32'd17, 32'd5, res, lat, sawDone);
    checkOutput("remu_17_5", res, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request sampled only in IDLE.
REQ-005 SHALL have port op, input, 3, RV32M funct3: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
REQ-006 SHALL have port a_in, input, 32, rs1 operand (dividend/multiplicand).
REQ-007 SHALL have port b_in, input, 32, rs2 operand (divisor/multiplier).
REQ-008 SHALL have port flush, input, 1, synchronous kill from pipeline redirect.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have port done, output, 1, single-cycle pulse; result valid that cycle.
REQ-011 SHALL have port result, output, 32, operation result; held until next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, PREP, CALC, FIX, DONE.
REQ-013 IDLE: start=1 and flush=0 at an edge latches op, a_in, b_in, enters PREP; start ignored in every other state.
REQ-014 PREP: record operand signs per op (MULH, DIV, REM: both signed; MULHSU: a only; others unsigned); replace signed negatives with magnitudes; load 5-bit iteration counter with 31.
REQ-015 PREP special cases go to FIX and skip CALC: divide by zero (DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a_in); signed overflow, DIV/REM with a=0x80000000 and b=0xFFFFFFFF (DIV -> 0x80000000, REM -> 0).
REQ-016 CALC multiply: radix-2 shift-add, one bit per cycle, 64-bit unsigned product after 32 cycles.
REQ-017 CALC divide: restoring shift-subtract, one quotient bit per cycle, 32-bit quotient and remainder after 32 cycles.
REQ-018 CALC exits to FIX when the counter is 0 (exactly 32 CALC cycles); counter does not wrap.
REQ-019 FIX: product negated when operand signs differ (signed ops); quotient negated when signs differ; remainder takes dividend sign; MUL selects low 32 bits, MULH/MULHSU/MULHU high 32 bits.
REQ-020 DONE: done=1 and result updated for one cycle, then IDLE unconditionally.
REQ-021 Latency: start sampled at edge T -> done high in cycle after edge T+35 (normal), T+3 (special case).
REQ-022 flush=1 in any state: next edge -> IDLE, no done pulse, result unchanged; flush has priority over start.
REQ-023 start with flush on the same edge in IDLE SHALL not be accepted.
REQ-024 Operand inputs may change after acceptance without affecting the result.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0, counter=0, internal operand/accumulator registers cleared.
REQ-026 Reset mid-operation SHALL abandon the operation with no done pulse; first start after release is accepted normally.

Structure
REQ-027 Package muldiv_pkg SHALL hold the XLEN constant, the op enum (funct3 values), and the FSM state enum; shared with decode and EX stage.
REQ-028 One sub-module is natural: muldiv_sign_fix (combinational magnitude/negate helpers for PREP and FIX); the FSM, counter and datapath stay in muldiv_unit.

Verification
REQ-029 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 35 cycles after start, busy high throughout.
REQ-030 MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-032 DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=7, b=0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; all with done 3 cycles after start.
REQ-033 Start DIV, assert flush in CALC cycle 10 -> IDLE next cycle, no done, result keeps prior value; start during busy ignored.
REQ-034 Drop rst_n mid-CALC -> busy, done, result 0 immediately; after release MUL 3x4 -> 12 in 35 cycles.
